// File: rtl/gate_test_pkg.sv
// Shared definitions for the gate self-test sequencer: FSM encoding, gate bit
// positions within gate_out, and the golden truth table indexed by vector {a,b}.
package gate_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_DWELL,
        ST_DONE
    } state_t;

    localparam int N_GATES = 6;
    localparam int N_VEC   = 4;

    localparam int G_AND  = 0;
    localparam int G_OR   = 1;
    localparam int G_NOT  = 2;
    localparam int G_XOR  = 3;
    localparam int G_NAND = 4;
    localparam int G_NOR  = 5;

    // Element [i] is the expected gate_out for vector {a,b} = i.
    localparam logic [N_VEC-1:0][N_GATES-1:0] EXP = {
        6'b000011,   // 11
        6'b011010,   // 10
        6'b011110,   // 01
        6'b110100    // 00
    };

    function automatic logic [N_GATES-1:0] expected_outputs(input logic [1:0] idx);
        return EXP[idx];
    endfunction

endpackage

// File: rtl/gts_timer.sv
// Loadable down-counter used for the settle and dwell intervals; counts down to
// zero and parks there, with zero asserted whenever the count is zero.
module gts_timer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // in the design updates from pre-edge values, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= value;
        end else if (count_q != '0) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/gate_test_sequencer.sv
// Self-test controller for the two-input gate block: sweeps {a,b} through all
// four vectors, samples gate_out after a settle time and publishes the verdict.
// Build option: GTS_CONTINUOUS_EN makes DONE last one cycle and re-sweep forever.
module gate_test_sequencer
    import gate_test_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int DWELL_CYCLES  = 16,
    parameter int CNT_W         = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 a,
    output logic                 b,
    input  logic [N_GATES-1:0]   gate_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_GATES-1:0]   err_mask,
    output logic [N_VEC-1:0]     fail_vec
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD  = CNT_W'((DWELL_CYCLES > 0) ? DWELL_CYCLES - 1 : 0);
    localparam bit               HAS_DWELL   = (DWELL_CYCLES > 0);

    state_t               state_q, state_d;
    logic [1:0]           idx_q, idx_d;
    logic [N_GATES-1:0]   acc_err_q, acc_err_d;
    logic [N_VEC-1:0]     acc_vec_q, acc_vec_d;
    logic [N_GATES-1:0]   mism;
    logic                 publish;
    logic                 restart;
    logic                 tmr_load;
    logic [CNT_W-1:0]     tmr_value;
    logic                 tmr_zero;

    gts_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tmr_load),
        .value (tmr_value),
        .zero  (tmr_zero)
    );

`ifdef GTS_CONTINUOUS_EN
    assign restart = 1'b1;
`else
    assign restart = start;
`endif

    assign mism = gate_out ^ expected_outputs(idx_q);

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_err_d = acc_err_q;
        acc_vec_d = acc_vec_q;
        tmr_load  = 1'b0;
        tmr_value = SETTLE_LOAD;
        publish   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_DRIVE;
                    idx_d     = 2'd0;
                    acc_err_d = '0;
                    acc_vec_d = '0;
                    tmr_load  = 1'b1;
                end
            end

            ST_DRIVE: begin
                if (tmr_zero) begin
                    state_d = ST_SAMPLE;
                end
            end

            ST_SAMPLE: begin
                acc_err_d        = acc_err_q | mism;
                acc_vec_d[idx_q] = |mism;
                if (HAS_DWELL) begin
                    state_d   = ST_DWELL;
                    tmr_load  = 1'b1;
                    tmr_value = DWELL_LOAD;
                end else if (idx_q == 2'd3) begin
                    state_d = ST_DONE;
                    publish = 1'b1;
                end else begin
                    state_d  = ST_DRIVE;
                    idx_d    = idx_q + 2'd1;
                    tmr_load = 1'b1;
                end
            end

            ST_DWELL: begin
                if (tmr_zero) begin
                    if (idx_q == 2'd3) begin
                        state_d = ST_DONE;
                        publish = 1'b1;
                    end else begin
                        state_d  = ST_DRIVE;
                        idx_d    = idx_q + 2'd1;
                        tmr_load = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                // Only the accumulators clear here; published results hold.
                if (restart) begin
                    state_d   = ST_DRIVE;
                    idx_d     = 2'd0;
                    acc_err_d = '0;
                    acc_vec_d = '0;
                    tmr_load  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= 2'd0;
            acc_err_q <= '0;
            acc_vec_q <= '0;
            a         <= 1'b0;
            b         <= 1'b0;
            pass      <= 1'b0;
            err_mask  <= '0;
            fail_vec  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            acc_err_q <= acc_err_d;
            acc_vec_q <= acc_vec_d;
            // a,b change only on DRIVE entry, so they hold 11 through DONE.
            if (state_d == ST_DRIVE) begin
                {a, b} <= idx_d;
            end
            if (publish) begin
                err_mask <= acc_err_d;
                fail_vec <= acc_vec_d;
                pass     <= ~|acc_err_d;
            end
        end
    end

    assign busy = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE) || (state_q == ST_DWELL);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Randomized self-checking bench: a behavioural gate model with injectable
// per-vector faults and between-sample glitches, checked against expected sweep results.
module tb_gate_test_sequencer;

    localparam int S   = 4;
    localparam int D   = 2;
    localparam int P   = S + 1 + D;
    localparam int LAT = 4 * P;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       a, b;
    logic [5:0] gate_out;
    logic       busy, done, pass;
    logic [5:0] err_mask;
    logic [3:0] fail_vec;

    logic [5:0] fault [4];
    logic [5:0] glitch;

    logic [5:0] exp_err;
    logic [3:0] exp_vec;
    logic       exp_pass;

    int n_tests = 0;
    int n_fail  = 0;

    gate_test_sequencer #(
        .SETTLE_CYCLES (S),
        .DWELL_CYCLES  (D),
        .CNT_W         (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .gate_out (gate_out),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_mask (err_mask),
        .fail_vec (fail_vec)
    );

    always #5 clk = ~clk;

    // Ideal gate block, bit order {nor,nand,xor,not,or,and}.
    function automatic logic [5:0] ideal(input logic va, input logic vb);
        return {~(va | vb), ~(va & vb), va ^ vb, ~va, va | vb, va & vb};
    endfunction

    always_comb begin
        gate_out = ideal(a, b) ^ fault[{a, b}] ^ glitch;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // kind: 0 ideal, 1 xor stuck-at-0, 2 not follows a, 3 random per-vector flips
    task automatic set_faults(input int kind);
        for (int v = 0; v < 4; v++) begin
            case (kind)
                1:       fault[v] = ideal(v[1], v[0]) & 6'b001000;
                2:       fault[v] = 6'b000100;
                3:       fault[v] = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
                default: fault[v] = 6'd0;
            endcase
        end
    endtask

    // Launches one sweep from the current negedge and follows it cycle by cycle.
    task automatic run_sweep(input bit hold, input bit pulse_during);
        logic [5:0] e_err;
        logic [3:0] e_vec;
        e_err = 6'd0;
        for (int v = 0; v < 4; v++) begin
            e_err    |= fault[v];
            e_vec[v]  = |fault[v];
        end
        start = 1'b1;
        @(negedge clk);
        start = hold;
        for (int n = 1; n <= LAT; n++) begin
            check("sweep_ab", {30'd0, a, b}, (n - 1) / P);
            check("sweep_busy", busy, 1'b1);
            check("sweep_done", done, 1'b0);
            if (n == 1) begin
                check("held_pass", pass, exp_pass);
                check("held_err_mask", err_mask, exp_err);
                check("held_fail_vec", fail_vec, exp_vec);
            end
            glitch = (((n - 1) % P) == S) ? 6'd0 : 6'($urandom);
            if (pulse_during && !hold) start = (n == 3) || (n == 10);
            @(negedge clk);
        end
        glitch   = 6'd0;
        exp_err  = e_err;
        exp_vec  = e_vec;
        exp_pass = (e_err == 6'd0);
        check("end_done", done, 1'b1);
        check("end_busy", busy, 1'b0);
        check("end_ab", {a, b}, 2'b11);
        check("end_pass", pass, exp_pass);
        check("end_err_mask", err_mask, exp_err);
        check("end_fail_vec", fail_vec, exp_vec);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ab"}, {a, b}, 2'b00);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_pass"}, pass, 1'b0);
        check({tag, "_err_mask"}, err_mask, 6'd0);
        check({tag, "_fail_vec"}, fail_vec, 4'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        glitch = 6'd0;
        set_faults(0);
        exp_err  = 6'd0;
        exp_vec  = 4'd0;
        exp_pass = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", busy, 1'b0);
        check("idle_done", done, 1'b0);

`ifdef GTS_CONTINUOUS_EN
        // One start launches back-to-back sweeps; a fault only on the second.
        run_sweep(1'b0, 1'b0);
        start = 1'b0;
        set_faults(1);
        run_sweep(1'b0, 1'b0);
        check("cont_pass_drop", pass, 1'b0);
        set_faults(0);
        run_sweep(1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            set_faults(3);
            run_sweep(1'b0, 1'b0);
        end
`else
        // Ideal block: clean result, DONE holds with start low.
        run_sweep(1'b0, 1'b0);
        check("t1_pass", pass, 1'b1);
        repeat (3) @(negedge clk);
        check("t1_done_holds", done, 1'b1);
        check("t1_ab_holds", {a, b}, 2'b11);

        set_faults(1);
        run_sweep(1'b0, 1'b0);
        check("t2_err_mask", err_mask, 6'b001000);
        check("t2_fail_vec", fail_vec, 4'b0110);

        set_faults(2);
        run_sweep(1'b0, 1'b0);
        check("t3_err_mask", err_mask, 6'b000100);
        check("t3_fail_vec", fail_vec, 4'b1111);

        // Start pulses mid-sweep must not disturb it.
        set_faults(0);
        run_sweep(1'b0, 1'b1);
        @(negedge clk);
        check("t5_no_restart", done, 1'b1);

        // Reset during DRIVE of vector 2 after a faulty sweep.
        set_faults(2);
        run_sweep(1'b0, 1'b0);
        set_faults(0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2 * P + 1) @(negedge clk);
        check("t4_ab_before", {a, b}, 2'b10);
        rst_n = 1'b0;
        #1;
        check_reset_values("t4");
        @(negedge clk);
        rst_n = 1'b1;
        exp_err  = 6'd0;
        exp_vec  = 4'd0;
        exp_pass = 1'b0;
        @(negedge clk);
        check("t4_idle", busy, 1'b0);
        run_sweep(1'b0, 1'b0);
        check("t4_clean_pass", pass, 1'b1);

        // Start held high through DONE restarts at once.
        set_faults(3);
        run_sweep(1'b1, 1'b0);
        set_faults(3);
        run_sweep(1'b1, 1'b0);
        start = 1'b0;
        @(negedge clk);
        check("hold_stop_done", done, 1'b1);

        for (int k = 0; k < 6; k++) begin
            set_faults(3);
            run_sweep(1'b0, ($urandom_range(0, 1) == 1));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
